// File: rtl/switch_event_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | switch_seq_pkg - shared types and helpers for the event sequencer  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package switch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic INIT_ON  = 1'b1;
  localparam logic INIT_OFF = 1'b0;

  // Width of an event counter able to hold the value N itself.
  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_event_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | switch_event_sequencer_if - config/run/status bundle, Rev 1.0      |
// +--------------------------------------------------------------------+
interface switch_event_sequencer_if #(
  parameter int N_EVENTS = 8,
  parameter int TW       = 32
);
  localparam int AW = $clog2(N_EVENTS);
  localparam int IW = switch_seq_pkg::idx_w(N_EVENTS);

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [TW-1:0] cfg_time;
  logic [IW-1:0] cfg_count;
  logic          start;
  logic          abort;
  logic          sw_ctrl;
  logic          sw_edge;
  logic [IW-1:0] event_idx;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output cfg_we, cfg_addr, cfg_time, cfg_count, start, abort,
    input  sw_ctrl, sw_edge, event_idx, busy, done, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_time, cfg_count, start, abort,
    output sw_ctrl, sw_edge, event_idx, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/switch_event_sequencer_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | switch_seq_table - toggle-time register file, write locked in run  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module switch_seq_table #(
  parameter int N_EVENTS = 8,
  parameter int TW       = 32
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic                        busy,
  input  logic [$clog2(N_EVENTS)-1:0] waddr,
  input  logic [TW-1:0]               wdata,
  input  logic [$clog2(N_EVENTS)-1:0] raddr,
  output logic [TW-1:0]               rdata
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [TW-1:0] r_mem [N_EVENTS];

  always_ff @(posedge clk) begin
    if (we && !busy) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/switch_event_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | switch_event_sequencer - timed toggle schedule to switch control   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module switch_event_sequencer
  import switch_seq_pkg::*;
#(
  parameter int   N_EVENTS = 8,
  parameter int   TW       = 32,
  parameter logic INIT     = INIT_OFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  switch_event_sequencer_if.slave  bus
);

  localparam int            AW          = $clog2(N_EVENTS);
  localparam int            IW          = idx_w(N_EVENTS);
  localparam logic [IW-1:0] C_MAX_COUNT = IW'(N_EVENTS);

  state_t        r_state;
  logic [TW-1:0] r_cnt;
  logic [IW-1:0] r_n;
  logic [IW-1:0] r_event_idx;
  logic          r_sw_ctrl;
  logic          r_sw_edge;
  logic          r_done;
  logic          r_busy;
  logic          r_err;

  logic [TW-1:0] w_ev_time;
  logic          w_hit;
  logic          w_late;
  logic          w_last;
  logic          w_wrap;
  logic          w_start_ok;

  switch_seq_table #(
    .N_EVENTS (N_EVENTS),
    .TW       (TW)
  ) u_table (
    .clk   (clk),
    .we    (bus.cfg_we),
    .busy  (r_busy),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_time),
    .raddr (r_event_idx[AW-1:0]),
    .rdata (w_ev_time)
  );

  // A late entry (time already passed) still fires so a bad table cannot stall the run.
  assign w_hit      = (r_cnt >= w_ev_time);
  assign w_late     = (r_cnt >  w_ev_time);
  assign w_last     = ((r_event_idx + IW'(1)) == r_n);
  assign w_wrap     = &r_cnt;
  assign w_start_ok = bus.start && !r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_n         <= '0;
      r_event_idx <= '0;
      r_sw_ctrl   <= INIT;
      r_sw_edge   <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sw_edge <= 1'b0;
      r_done    <= 1'b0;
      if (bus.abort) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_event_idx <= '0;
        r_sw_ctrl   <= INIT;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE, FINISH: begin
            // busy lingers for the done cycle, then drops here
            if (r_state == FINISH) r_busy <= 1'b0;
            if (w_start_ok) begin
              if (bus.cfg_count > C_MAX_COUNT) begin
                r_err <= 1'b1;
              end else begin
                r_n         <= bus.cfg_count;
                r_cnt       <= '0;
                r_event_idx <= '0;
                r_sw_ctrl   <= INIT;
                r_busy      <= 1'b1;
                if (bus.cfg_count == '0) begin
                  r_done  <= 1'b1;
                  r_state <= FINISH;
                end else begin
                  r_state <= RUN;
                end
              end
            end
          end
          RUN: begin
            r_cnt <= r_cnt + TW'(1);
            if (w_hit && (w_last || !w_wrap)) begin
              r_sw_ctrl   <= ~r_sw_ctrl;
              r_sw_edge   <= 1'b1;
              r_event_idx <= r_event_idx + IW'(1);
              if (w_late) r_err <= 1'b1;
              if (w_last) begin
                r_done  <= 1'b1;
                r_state <= FINISH;
              end
            end else if (w_wrap) begin
              r_err   <= 1'b1;
              r_state <= FINISH;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sw_ctrl   = r_sw_ctrl;
  assign bus.sw_edge   = r_sw_edge;
  assign bus.event_idx = r_event_idx;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_switch_event_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_switch_event_sequencer - directed bench, INIT=0 and INIT=1 DUTs |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_switch_event_sequencer;

  localparam int N  = 8;
  localparam int TW = 8;
  localparam int IW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  switch_event_sequencer_if #(.N_EVENTS(N), .TW(TW)) bus ();
  switch_event_sequencer_if #(.N_EVENTS(N), .TW(TW)) bus1 ();

  // The INIT=1 instance sees exactly the same stimulus.
  assign bus1.cfg_we    = bus.cfg_we;
  assign bus1.cfg_addr  = bus.cfg_addr;
  assign bus1.cfg_time  = bus.cfg_time;
  assign bus1.cfg_count = bus.cfg_count;
  assign bus1.start     = bus.start;
  assign bus1.abort     = bus.abort;

  switch_event_sequencer #(.N_EVENTS(N), .TW(TW), .INIT(1'b0)) u_dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );

  switch_event_sequencer #(.N_EVENTS(N), .TW(TW), .INIT(1'b1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int t);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'(a);
    bus.cfg_time = TW'(t);
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic go(input int c);
    bus.cfg_count = IW'(c);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (bus.sw_ctrl !== 1'b0) begin errors++; $display("FAIL reset_ctrl0: got %b expected 0", bus.sw_ctrl); end
    checks++; if (bus1.sw_ctrl !== 1'b1) begin errors++; $display("FAIL reset_ctrl1: got %b expected 1", bus1.sw_ctrl); end
    checks++; if ({bus.sw_edge, bus.busy, bus.done, bus.err} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.sw_edge, bus.busy, bus.done, bus.err}); end
    checks++; if (bus.event_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", bus.event_idx); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic ec, ee, ed, eb;
    logic [IW-1:0] ei;
    wr(0, 5); wr(1, 10); wr(2, 20);
    go(3);
    for (int k = 1; k <= 24; k++) begin
      ec = (k >= 7 && k < 12) || k >= 22;
      ee = (k == 7 || k == 12 || k == 22);
      ed = (k == 22);
      eb = (k <= 22);
      ei = IW'((k >= 22) ? 3 : (k >= 12) ? 2 : (k >= 7) ? 1 : 0);
      checks++; if (bus.sw_ctrl !== ec) begin errors++; $display("FAIL basic_ctrl c%0d: got %b expected %b", k, bus.sw_ctrl, ec); end
      checks++; if (bus1.sw_ctrl !== ~ec) begin errors++; $display("FAIL basic_ctrl_init1 c%0d: got %b expected %b", k, bus1.sw_ctrl, ~ec); end
      checks++; if (bus.sw_edge !== ee) begin errors++; $display("FAIL basic_edge c%0d: got %b expected %b", k, bus.sw_edge, ee); end
      checks++; if (bus.done !== ed) begin errors++; $display("FAIL basic_done c%0d: got %b expected %b", k, bus.done, ed); end
      checks++; if (bus.busy !== eb) begin errors++; $display("FAIL basic_busy c%0d: got %b expected %b", k, bus.busy, eb); end
      checks++; if (bus.event_idx !== ei) begin errors++; $display("FAIL basic_idx c%0d: got %0d expected %0d", k, bus.event_idx, ei); end
      tick();
    end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_empty();
    // previous run left sw_ctrl high, so this also checks the INIT reload
    go(0);
    for (int k = 1; k <= 4; k++) begin
      checks++; if (bus.done !== (k == 1)) begin errors++; $display("FAIL empty_done c%0d: got %b expected %b", k, bus.done, (k == 1)); end
      checks++; if (bus.sw_edge !== 1'b0) begin errors++; $display("FAIL empty_edge c%0d: got %b expected 0", k, bus.sw_edge); end
      checks++; if (bus.sw_ctrl !== 1'b0) begin errors++; $display("FAIL empty_ctrl c%0d: got %b expected 0", k, bus.sw_ctrl); end
      checks++; if (bus.event_idx !== 4'd0) begin errors++; $display("FAIL empty_idx c%0d: got %0d expected 0", k, bus.event_idx); end
      if (k >= 2) begin
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL empty_busy c%0d: got %b expected 0", k, bus.busy); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic ec, ee;
    logic [IW-1:0] ei;
    wr(0, 0); wr(1, 1); wr(2, 2);
    go(3);
    for (int k = 1; k <= 6; k++) begin
      ec = (k == 2) || (k >= 4);
      ee = (k >= 2 && k <= 4);
      ei = IW'((k < 2) ? 0 : (k > 4) ? 3 : k - 1);
      checks++; if (bus.sw_ctrl !== ec) begin errors++; $display("FAIL b2b_ctrl c%0d: got %b expected %b", k, bus.sw_ctrl, ec); end
      checks++; if (bus1.sw_ctrl !== ~ec) begin errors++; $display("FAIL b2b_ctrl_init1 c%0d: got %b expected %b", k, bus1.sw_ctrl, ~ec); end
      checks++; if (bus1.sw_edge !== ee) begin errors++; $display("FAIL b2b_edge c%0d: got %b expected %b", k, bus1.sw_edge, ee); end
      checks++; if (bus1.done !== (k == 4)) begin errors++; $display("FAIL b2b_done c%0d: got %b expected %b", k, bus1.done, (k == 4)); end
      checks++; if (bus1.event_idx !== ei) begin errors++; $display("FAIL b2b_idx c%0d: got %0d expected %0d", k, bus1.event_idx, ei); end
      tick();
    end
  endtask

  task automatic test_abort();
    logic ec;
    wr(0, 5); wr(1, 20);
    go(2);
    for (int k = 1; k <= 25; k++) begin
      ec = (k >= 7 && k <= 9);
      checks++; if (bus.sw_ctrl !== ec) begin errors++; $display("FAIL abort_ctrl c%0d: got %b expected %b", k, bus.sw_ctrl, ec); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done c%0d: got %b expected 0", k, bus.done); end
      checks++; if (bus.busy !== (k <= 9)) begin errors++; $display("FAIL abort_busy c%0d: got %b expected %b", k, bus.busy, (k <= 9)); end
      checks++; if (bus.event_idx !== IW'(ec ? 1 : 0)) begin errors++; $display("FAIL abort_idx c%0d: got %0d expected %0d", k, bus.event_idx, ec); end
      if (k == 9) bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
    end
    go(2);
    for (int k = 1; k <= 23; k++) begin
      ec = (k >= 7 && k < 22);
      checks++; if (bus.sw_ctrl !== ec) begin errors++; $display("FAIL replay_ctrl c%0d: got %b expected %b", k, bus.sw_ctrl, ec); end
      checks++; if (bus.done !== (k == 22)) begin errors++; $display("FAIL replay_done c%0d: got %b expected %b", k, bus.done, (k == 22)); end
      tick();
    end
    checks++; if (bus.event_idx !== 4'd2) begin errors++; $display("FAIL replay_idx: got %0d expected 2", bus.event_idx); end
  endtask

  task automatic test_non_ascending();
    wr(0, 8); wr(1, 4);
    go(2);
    for (int k = 1; k <= 13; k++) begin
      checks++; if (bus.sw_ctrl !== (k == 10)) begin errors++; $display("FAIL nasc_ctrl c%0d: got %b expected %b", k, bus.sw_ctrl, (k == 10)); end
      checks++; if (bus.sw_edge !== (k == 10 || k == 11)) begin errors++; $display("FAIL nasc_edge c%0d: got %b expected %b", k, bus.sw_edge, (k == 10 || k == 11)); end
      checks++; if (bus.done !== (k == 11)) begin errors++; $display("FAIL nasc_done c%0d: got %b expected %b", k, bus.done, (k == 11)); end
      checks++; if (bus.err !== (k >= 11)) begin errors++; $display("FAIL nasc_err c%0d: got %b expected %b", k, bus.err, (k >= 11)); end
      tick();
    end
    go(0);
    tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL nasc_err_sticky: got %b expected 1", bus.err); end
  endtask

  task automatic test_reset_midrun();
    logic ec;
    wr(0, 5); wr(1, 10);
    go(2);
    for (int k = 1; k <= 8; k++) begin
      checks++; if (bus.sw_ctrl !== (k >= 7)) begin errors++; $display("FAIL rmid_ctrl c%0d: got %b expected %b", k, bus.sw_ctrl, (k >= 7)); end
      if (k == 3) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_time = TW'(2);
      end
      if (k < 8) tick();
      bus.cfg_we = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.sw_ctrl, bus.sw_edge, bus.busy, bus.done, bus.err} !== 5'b00000) begin errors++; $display("FAIL rmid_async_flags: got %b expected 00000", {bus.sw_ctrl, bus.sw_edge, bus.busy, bus.done, bus.err}); end
    checks++; if (bus.event_idx !== 4'd0) begin errors++; $display("FAIL rmid_async_idx: got %0d expected 0", bus.event_idx); end
    tick();
    rst_n = 1'b1;
    tick();
    go(2);
    for (int k = 1; k <= 13; k++) begin
      ec = (k >= 7 && k < 12);
      checks++; if (bus.sw_ctrl !== ec) begin errors++; $display("FAIL rmid_replay_ctrl c%0d: got %b expected %b", k, bus.sw_ctrl, ec); end
      checks++; if (bus.done !== (k == 12)) begin errors++; $display("FAIL rmid_replay_done c%0d: got %b expected %b", k, bus.done, (k == 12)); end
      tick();
    end
  endtask

  task automatic test_bad_count();
    go(9);
    for (int k = 1; k <= 3; k++) begin
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL badcnt_err c%0d: got %b expected 1", k, bus.err); end
      checks++; if ({bus.busy, bus.done, bus.sw_edge} !== 3'b000) begin errors++; $display("FAIL badcnt_flags c%0d: got %b expected 000", k, {bus.busy, bus.done, bus.sw_edge}); end
      tick();
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wr(0, 255); wr(1, 255);
    go(2);
    for (int k = 1; k <= 259; k++) begin
      checks++; if ({bus.sw_ctrl, bus.sw_edge, bus.done} !== 3'b000) begin errors++; $display("FAIL wrap_flags c%0d: got %b expected 000", k, {bus.sw_ctrl, bus.sw_edge, bus.done}); end
      checks++; if (bus.err !== (k >= 257)) begin errors++; $display("FAIL wrap_err c%0d: got %b expected %b", k, bus.err, (k >= 257)); end
      if (k != 257) begin
        checks++; if (bus.busy !== (k <= 256)) begin errors++; $display("FAIL wrap_busy c%0d: got %b expected %b", k, bus.busy, (k <= 256)); end
      end
      tick();
    end
    checks++; if (bus.event_idx !== 4'd0) begin errors++; $display("FAIL wrap_idx: got %0d expected 0", bus.event_idx); end
  endtask

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_time  = '0;
    bus.cfg_count = '0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    test_reset();
    test_basic();
    test_empty();
    test_back_to_back();
    test_abort();
    test_non_ascending();
    test_reset_midrun();
    test_bad_count();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/switch_event_sequencer.md
# switch_event_sequencer

- Digital control source for the time-scheduled `Switch` primitive.
- Converts a programmed list of toggle times into a clean on/off control level with per-event strobes, using a free-running cycle counter.
- Sits directly upstream of the switch model's control node and replaces the fixed `pulse` source with a multi-event schedule (`time="[t0; t1; ...]"` semantics).

## Interface
- `N_EVENTS`, default 8: depth of the toggle-time table (power of two, 2–64).
- `TW`, default 32: width of time values and of the cycle counter.
- `INIT`, default 0: switch state before the first event (1 = on, 0 = off).
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cfg_we` in 1: table write strobe; ignored unless idle.
- `cfg_addr` in clog2(N_EVENTS): table entry index.
- `cfg_time` in TW: absolute toggle time, in cycles after start.
- `cfg_count` in clog2(N_EVENTS)+1: number of valid entries; sampled on `start`.
- `start` in 1: single-cycle run request.
- `abort` in 1: stops the run and returns to idle.
- `sw_ctrl` out 1: switch control level.
- `sw_edge` out 1: one-cycle strobe on each toggle.
- `event_idx` out clog2(N_EVENTS)+1: number of events executed so far.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle strobe when the last event executes.
- `err` out 1: sticky schedule error.

## Operation
- **States:** IDLE, RUN, FINISH.
- **IDLE**
  - Table writes are accepted.
  - `sw_ctrl` holds `INIT`; `cnt` = 0.
- **IDLE→RUN** on `start`:
  - Latch `cfg_count` into `n`.
  - `cnt` resets to 0 and increments once per cycle in RUN.
  - If `cfg_count` = 0: go straight to FINISH, with `done` pulsed and no toggle.
  - If `cfg_count` > N_EVENTS: set `err` and stay in IDLE.
- **In RUN**, when `cnt == table[event_idx]`:
  - Toggle `sw_ctrl`, pulse `sw_edge`, increment `event_idx`.
  - When `event_idx` reaches `n`: pulse `done` and go to FINISH.
- **Ordering rule:** entries must be strictly ascending.
  - If `table[k] <= table[k-1]`, that event can never match.
  - When the event is reached with `cnt` already greater than its time, set `err`, execute the event immediately (toggle), and continue.
  - This gives a no-deadlock guarantee.
- **Counter wrap:** reaching all-ones without finishing sets `err` and moves to FINISH with `sw_ctrl` held.
- **FINISH**
  - `sw_ctrl` holds its final level; `busy` = 0.
  - `start` restarts the run: `sw_ctrl` reloads `INIT` on that cycle.
- **abort** (any state): go to IDLE, `sw_ctrl` ← `INIT`, `event_idx` ← 0, no `done`. Abort has priority over `start` and over an event in the same cycle.
- **Clearing `err`:** only reset clears it; `start` does not.
- **`start` while busy:** ignored.
- **`cfg_we` while busy:** ignored; the table is unchanged.

## Timing
- **Reset values:** `sw_ctrl`=`INIT`, `sw_edge`=0, `event_idx`=0, `busy`=0, `done`=0, `err`=0, state=IDLE, `cnt`=0; table contents are don't-care.
- **Start:** `start` in cycle c gives `busy`=1 from c+1; `cnt`=0 in cycle c+1.
- **Event latency:** an event at time T toggles `sw_ctrl` registered at cycle c+1+T+1, i.e. one cycle after `cnt==T` is seen. T=0 therefore toggles at c+2.
- **Same-cycle outputs:**
  - `sw_edge` and `done` are asserted in the same cycle as the registered toggle.
  - `busy` deasserts in the cycle after `done`.
- **Throughput:** at most one event per cycle. Consecutive times T, T+1 produce toggles on consecutive cycles.
- **Abort:** takes effect on the next edge.
- **All outputs are registered.**

## Structure
- Shared package `switch_seq_pkg`:
  - state enum {IDLE, RUN, FINISH}
  - `INIT_ON`/`INIT_OFF` constants
  - function `idx_w(N)` returning clog2(N)+1
- Table: a register array of N_EVENTS×TW with a single write port and a combinational read at `event_idx`.
- One natural sub-module: `switch_seq_table` (register file, write gated by `!busy`).
- Counter, comparator and FSM live in the top module.

## Test plan
- **Basic schedule:** INIT=0, table {5,10,20}, count=3, start at c0 → `sw_ctrl` rises at c7, falls at c12, rises at c22; `done` at c22; `busy` low at c23.
- **Empty schedule:** count=0, start → `done` one cycle later; no `sw_edge`; `sw_ctrl` stays 0.
- **Back-to-back times:** table {0,1,2}, INIT=1 → toggles at c2, c3, c4 (0,1,0); `event_idx` ends at 3.
- **Non-ascending entry:** table {8,4}, count=2 → toggle at c10 and again at c11; `err`=1 and stays set until reset.
- **Abort mid-run:** abort at c9 during table {5,20} → `sw_ctrl` back to INIT at c10; no `done`; `event_idx`=0; the next start replays from the beginning.
- **Reset mid-run:** `rst_n` low at c8 → all outputs at reset values immediately; `cfg_we` during busy leaves the table unchanged (check by reading back with a subsequent run).
